serial_adder: RTL and testbench

- Bit-serial N-bit adder, the additive counterpart of the team's gate-level full subtractor.
- Accepts two WIDTH-bit operands and a carry-in through a start/ready handshake.
- Computes the sum one bit per clock, LSB first, with a single full-adder cell and a carry flip-flop.
- Presents the registered sum and carry-out with a one-cycle done pulse. Serves as the low-area arithmetic unit in datapaths where latency is cheaper than a parallel adder.

---
 rtl/serial_adder.sv | 118 +++++++++++
 tb/tb_serial_adder.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/serial_adder.sv
// Bit-serial WIDTH-bit adder: one full-adder cell plus a carry flop, LSB first.
// A start/ready handshake loads the operands, the sum is produced over WIDTH
// clocks, and the registered {cout, sum} is presented with a one-cycle done.
module serial_adder #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             ready,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    state_e             state_q, state_d;
    logic [WIDTH-1:0]   a_sr_q, a_sr_d;
    logic [WIDTH-1:0]   b_sr_q, b_sr_d;
    logic [WIDTH-1:0]   res_q, res_d;
    logic [WIDTH-1:0]   sum_q, sum_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               c_q, c_d;
    logic               cout_q, cout_d;
    logic               s_bit;
    logic               c_next;

    // Next-state, datapath shift and result-load logic.
    always_comb begin
        // NOTE: every signal gets a default first so no path can infer a latch.
        state_d = state_q;
        a_sr_d  = a_sr_q;
        b_sr_d  = b_sr_q;
        res_d   = res_q;
        sum_d   = sum_q;
        cnt_d   = cnt_q;
        c_d     = c_q;
        cout_d  = cout_q;

        // The single full-adder cell working on the current LSBs.
        s_bit  = a_sr_q[0] ^ b_sr_q[0] ^ c_q;
        c_next = (a_sr_q[0] & b_sr_q[0]) | (c_q & (a_sr_q[0] ^ b_sr_q[0]));

        case (state_q)
            IDLE: begin
                if (start) begin
                    a_sr_d  = a;
                    b_sr_d  = b;
                    c_d     = cin;
                    cnt_d   = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                a_sr_d = a_sr_q >> 1;
                b_sr_d = b_sr_q >> 1;
                c_d    = c_next;
                // New bit enters at the MSB so the LSB lands at bit 0 after WIDTH shifts.
                res_d  = (res_q >> 1) | (WIDTH'(s_bit) << (WIDTH - 1));
                cnt_d  = cnt_q + 1'b1;
                if (cnt_q == LAST_BIT) begin
                    sum_d   = res_d;
                    cout_d  = c_next;
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers, cleared asynchronously.
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: sequential state uses non-blocking assignments so all flops update together.
        if (!rst_n) begin
            state_q <= IDLE;
            a_sr_q  <= '0;
            b_sr_q  <= '0;
            res_q   <= '0;
            sum_q   <= '0;
            cnt_q   <= '0;
            c_q     <= 1'b0;
            cout_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            a_sr_q  <= a_sr_d;
            b_sr_q  <= b_sr_d;
            res_q   <= res_d;
            sum_q   <= sum_d;
            cnt_q   <= cnt_d;
            c_q     <= c_d;
            cout_q  <= cout_d;
        end
    end

    assign ready = (state_q == IDLE);
    assign busy  = (state_q == RUN);
    assign done  = (state_q == DONE);
    assign sum   = sum_q;
    assign cout  = cout_q;

endmodule

// File: tb/tb_serial_adder.sv
// Self-checking bench for serial_adder: four instances (WIDTH 1, 8, 13, 16)
// share clock, reset and operand buses; each has its own start line.
module tb_serial_adder;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] a_i = '0;
    logic [31:0] b_i = '0;
    logic        cin_i = 1'b0;
    logic [3:0]  start_i = '0;

    logic [0:0]  sum_1;
    logic [7:0]  sum_8;
    logic [12:0] sum_13;
    logic [15:0] sum_16;
    logic [3:0]  ready_o, busy_o, done_o, cout_o;

    int passed = 0;
    int total  = 0;
    int wid[4] = '{1, 8, 13, 16};

    always #5 clk = ~clk;

    serial_adder #(.WIDTH(1)) u_w1 (
        .clk(clk), .rst_n(rst_n), .start(start_i[0]), .a(a_i[0:0]), .b(b_i[0:0]), .cin(cin_i),
        .ready(ready_o[0]), .busy(busy_o[0]), .done(done_o[0]), .sum(sum_1), .cout(cout_o[0]));
    serial_adder #(.WIDTH(8)) u_w8 (
        .clk(clk), .rst_n(rst_n), .start(start_i[1]), .a(a_i[7:0]), .b(b_i[7:0]), .cin(cin_i),
        .ready(ready_o[1]), .busy(busy_o[1]), .done(done_o[1]), .sum(sum_8), .cout(cout_o[1]));
    serial_adder #(.WIDTH(13)) u_w13 (
        .clk(clk), .rst_n(rst_n), .start(start_i[2]), .a(a_i[12:0]), .b(b_i[12:0]), .cin(cin_i),
        .ready(ready_o[2]), .busy(busy_o[2]), .done(done_o[2]), .sum(sum_13), .cout(cout_o[2]));
    serial_adder #(.WIDTH(16)) u_w16 (
        .clk(clk), .rst_n(rst_n), .start(start_i[3]), .a(a_i[15:0]), .b(b_i[15:0]), .cin(cin_i),
        .ready(ready_o[3]), .busy(busy_o[3]), .done(done_o[3]), .sum(sum_16), .cout(cout_o[3]));

    function automatic logic [31:0] get_sum(input int sel);
        case (sel)
            0:       return 32'(sum_1);
            1:       return 32'(sum_8);
            2:       return 32'(sum_13);
            default: return 32'(sum_16);
        endcase
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference: {cout, sum} = a + b + cin, truncated to WIDTH+1 bits.
    function automatic logic [63:0] ref_add(input int w, input logic [31:0] av,
                                           input logic [31:0] bv, input logic ci);
        logic [63:0] mask = (64'd1 << w) - 64'd1;
        logic [63:0] full = (64'(av) & mask) + (64'(bv) & mask) + 64'(ci);
        return full & ((mask << 1) | 64'd1);
    endfunction

    // One full transaction on instance sel, starting right after a clock edge
    // with the instance idle. Checks latency, RUN behaviour, result and return to IDLE.
    task automatic run_op(input int sel, input logic [31:0] av, input logic [31:0] bv,
                          input logic ci, input string tag);
        int          w = wid[sel];
        logic [63:0] exp = ref_add(w, av, bv, ci);
        logic [31:0] prev_sum;
        logic        prev_cout;
        bit          run_ok = 1'b1;
        int          k = 0;

        check({tag, ".ready_before"}, 64'(ready_o[sel]), 64'd1);
        prev_sum  = get_sum(sel);
        prev_cout = cout_o[sel];
        a_i = av; b_i = bv; cin_i = ci; start_i[sel] = 1'b1;
        tick();
        start_i[sel] = 1'b0;
        // Operands may change freely after acceptance.
        a_i = $urandom; b_i = $urandom; cin_i = 1'($urandom);
        while (!done_o[sel] && k <= w + 3) begin
            if (busy_o[sel] !== 1'b1 || ready_o[sel] !== 1'b0 ||
                get_sum(sel) !== prev_sum || cout_o[sel] !== prev_cout)
                run_ok = 1'b0;
            tick();
            k++;
        end
        check({tag, ".run_stable"}, 64'(run_ok), 64'd1);
        check({tag, ".latency"}, 64'(k), 64'(w));
        check({tag, ".done"}, 64'(done_o[sel]), 64'd1);
        check({tag, ".busy_done"}, {62'd0, busy_o[sel], ready_o[sel]}, 64'd0);
        check({tag, ".result"}, {31'd0, cout_o[sel], get_sum(sel)},
              {31'd0, exp[w], 32'(exp & ((64'd1 << w) - 64'd1))});
        tick();
        check({tag, ".after"}, {61'd0, done_o[sel], ready_o[sel], cout_o[sel]},
              {61'd0, 1'b0, 1'b1, exp[w]});
    endtask

    initial begin
        logic [31:0] ra, rb;
        logic        rc;
        int          n_done;
        int          done_at[$];
        logic [31:0] res_at[$];
        logic        cout_at[$];

        // Reset state of every instance.
        #2;
        for (int s = 0; s < 4; s++) begin
            check($sformatf("reset%0d", s),
                  {27'd0, ready_o[s], busy_o[s], done_o[s], cout_o[s], (get_sum(s) != 0)},
                  {27'd0, 5'b10000});
        end
        #20;
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        // Directed WIDTH=8 cases.
        run_op(1, 32'h3C, 32'h5A, 1'b0, "w8_3c_5a");
        run_op(1, 32'hFF, 32'h01, 1'b0, "w8_ff_01");
        run_op(1, 32'hFF, 32'hFF, 1'b1, "w8_ff_ff_c");
        run_op(1, 32'h00, 32'h00, 1'b1, "w8_00_00_c");

        // start held through RUN and DONE: only the first IDLE edge accepts again.
        n_done = 0;
        a_i = 32'h10; b_i = 32'h20; cin_i = 1'b0; start_i[1] = 1'b1;
        tick();
        a_i = 32'hAA; b_i = 32'h55;
        for (int c = 1; c <= 30; c++) begin
            tick();
            if (c == 10) start_i[1] = 1'b0;
            if (done_o[1]) begin
                n_done++;
                done_at.push_back(c);
                res_at.push_back(get_sum(1));
                cout_at.push_back(cout_o[1]);
            end
        end
        check("hold.n_done", 64'(n_done), 64'd2);
        if (n_done == 2) begin
            check("hold.first_at", 64'(done_at[0]), 64'd8);
            check("hold.first", {31'd0, cout_at[0], res_at[0]}, 64'h30);
            check("hold.second_at", 64'(done_at[1]), 64'd18);
            check("hold.second", {31'd0, cout_at[1], res_at[1]}, 64'hFF);
        end

        // Asynchronous reset in the middle of RUN.
        a_i = 32'h0F; b_i = 32'h01; cin_i = 1'b0; start_i[1] = 1'b1;
        tick();
        start_i[1] = 1'b0;
        repeat (4) @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        check("abort.state", {27'd0, ready_o[1], busy_o[1], done_o[1], cout_o[1], (sum_8 != 0)},
              {27'd0, 5'b10000});
        n_done = 0;
        repeat (12) begin
            @(posedge clk);
            #1;
            if (done_o[1]) n_done++;
        end
        @(negedge clk);
        rst_n = 1'b1;
        for (int c = 0; c < 12; c++) begin
            tick();
            if (done_o[1]) n_done++;
        end
        check("abort.no_done", 64'(n_done), 64'd0);
        run_op(1, 32'h0F, 32'h01, 1'b0, "w8_after_abort");

        // Width boundaries.
        run_op(0, 32'h1, 32'h1, 1'b1, "w1_1_1_c");
        run_op(0, 32'h0, 32'h1, 1'b0, "w1_0_1");
        run_op(3, 32'hFFFF, 32'h0001, 1'b0, "w16_ffff_0001");

        // Random back-to-back traffic at WIDTH=8 and WIDTH=13.
        for (int i = 0; i < 1000; i++) begin
            ra = $urandom; rb = $urandom; rc = 1'($urandom);
            run_op(1, ra, rb, rc, "rnd_w8");
        end
        for (int i = 0; i < 1000; i++) begin
            ra = $urandom; rb = $urandom; rc = 1'($urandom);
            run_op(2, ra, rb, rc, "rnd_w13");
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
